// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   - state_e      : sequencer states (IDLE / RUN / HALTED)
//   - *_DEF        : default address / instruction widths and halt encoding
//   - PSEL_*       : ProgSel encodings selecting a program entry point
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned INST_W_DEF = 9;

  localparam logic [INST_W_DEF-1:0] HALT_WORD_DEF = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } state_e;

  localparam logic [1:0] PSEL_PROG0 = 2'd0;
  localparam logic [1:0] PSEL_PROG1 = 2'd1;
  localparam logic [1:0] PSEL_PROG2 = 2'd2;
  localparam logic [1:0] PSEL_ALT0  = 2'd3;  // aliases program 0

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC selection.
//   pc         in  current program counter
//   branch_en  in  take a branch instead of incrementing
//   branch_rel in  1 = target is a two's-complement offset, 0 = absolute
//   target     in  branch target or offset
//   pc_nxt     out next program counter (wraps mod 2^ADDR_W)
module pc_next #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_en,
  input  logic              branch_rel,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc + 1'b1;
    if (branch_en) begin
      // The offset is already ADDR_W wide, so sign extension to ADDR_W is the
      // identity and a plain modular add gives the signed relative target.
      pc_nxt = branch_rel ? (pc + target) : target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the instruction ROM.
//   Clk, Reset       clock and synchronous active-high reset
//   Start, ProgSel   launch request and entry-point select
//   InstIn           ROM word for the current InstAddress (same cycle)
//   Stall            hold the PC (halt not recognised while stalled)
//   BranchEn/BranchRel/Target  branch control
//   InstAddress      registered PC driven to the ROM
//   Running          high while in RUN
//   Done             one-cycle pulse after a halt is retired
//   CycleCount       saturating count of RUN cycles for the current/last program
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned            ADDR_W      = ADDR_W_DEF,
  parameter int unsigned            INST_W      = INST_W_DEF,
  parameter int unsigned            CNT_W       = 16,
  parameter logic [ADDR_W-1:0]      PROG0_START = '0,
  parameter logic [ADDR_W-1:0]      PROG1_START = 11'd512,
  parameter logic [ADDR_W-1:0]      PROG2_START = 11'd1024,
  parameter logic [INST_W-1:0]      HALT_WORD   = HALT_WORD_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        ProgSel,
  input  logic [INST_W-1:0] InstIn,
  input  logic              Stall,
  input  logic              BranchEn,
  input  logic              BranchRel,
  input  logic [ADDR_W-1:0] Target,
  output logic [ADDR_W-1:0] InstAddress,
  output logic              Running,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCount
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [ADDR_W-1:0]  entry;

  pc_next #(
    .ADDR_W(ADDR_W)
  ) u_pc_next (
    .pc        (pc_q),
    .branch_en (BranchEn),
    .branch_rel(BranchRel),
    .target    (Target),
    .pc_nxt    (pc_nxt)
  );

  always_comb begin
    unique case (ProgSel)
      PSEL_PROG1: entry = PROG1_START;
      PSEL_PROG2: entry = PROG2_START;
      PSEL_PROG0,
      PSEL_ALT0:  entry = PROG0_START;
      default:    entry = PROG0_START;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (!Stall && (InstIn == HALT_WORD)) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else if (!Stall) begin
          pc_d = pc_nxt;
        end
      end
      ST_IDLE,
      ST_HALTED: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = entry;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign InstAddress = pc_q;
  assign Running     = (state_q == ST_RUN);
  assign Done        = done_q;
  assign CycleCount  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// random stimulus, all compared cycle by cycle against a behavioural model.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, BranchEn, BranchRel;
  logic [1:0]  ProgSel;
  logic [8:0]  InstIn;
  logic [10:0] Target;
  logic [10:0] InstAddress;
  logic        Running, Done;
  logic [15:0] CycleCount;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_pc = 0;
  int m_cnt = 0;
  bit m_run = 0;
  bit m_done = 0;

  fetch_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ProgSel    (ProgSel),
    .InstIn     (InstIn),
    .Stall      (Stall),
    .BranchEn   (BranchEn),
    .BranchRel  (BranchRel),
    .Target     (Target),
    .InstAddress(InstAddress),
    .Running    (Running),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int entry_of(input int sel);
    case (sel)
      1: return 512;
      2: return 1024;
      default: return 0;
    endcase
  endfunction

  // One clock: apply inputs, advance the model by the same rules, compare.
  task automatic step(input bit rst, input bit st, input int sel, input int inst,
                      input bit stl, input bit be, input bit rel, input int tgt);
    int off;
    Reset = rst; Start = st; ProgSel = 2'(sel); InstIn = 9'(inst);
    Stall = stl; BranchEn = be; BranchRel = rel; Target = 11'(tgt);
    @(posedge Clk);
    if (rst) begin
      m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (st) begin
        m_run = 1; m_pc = entry_of(sel); m_cnt = 0;
      end
    end else begin
      m_done = 0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!stl && inst == 511) begin
        m_run = 0; m_done = 1;
      end else if (!stl) begin
        if (be) begin
          off = (tgt >= 1024) ? tgt - 2048 : tgt;
          m_pc = rel ? (m_pc + off + 2048) % 2048 : tgt;
        end else begin
          m_pc = (m_pc + 1) % 2048;
        end
      end
    end
    #1;
    chk("addr", 32'(InstAddress), 32'(m_pc));
    chk("running", 32'(Running), 32'(m_run));
    chk("done", 32'(Done), 32'(m_done));
    chk("cycles", 32'(CycleCount), 32'(m_cnt));
  endtask

  // Shorthands
  task automatic plain(input int inst);
    step(0, 0, 0, inst, 0, 0, 0, 0);
  endtask
  task automatic br(input bit rel, input int tgt);
    step(0, 0, 0, 12, 0, 1, rel, tgt);
  endtask

  initial begin
    // Reset
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_addr", 32'(InstAddress), 32'd0);
    chk("rst_running", 32'(Running), 32'd0);
    chk("rst_cycles", 32'(CycleCount), 32'd0);

    // Launch program 1, three plain instructions, then halt
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("launch_p1", 32'(InstAddress), 32'd512);
    plain(3); plain(7); plain(100);
    chk("seq_515", 32'(InstAddress), 32'd515);
    plain(511);
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_cycles", 32'(CycleCount), 32'd4);
    plain(0);
    chk("done_once", 32'(Done), 32'd0);
    chk("halt_hold_pc", 32'(InstAddress), 32'd515);

    // Branches
    step(0, 1, 0, 0, 0, 0, 0, 0);
    br(0, 10);
    br(0, 100);
    chk("br_abs", 32'(InstAddress), 32'd100);
    br(1, 11'h7FE);
    chk("br_rel_neg", 32'(InstAddress), 32'd98);
    br(0, 2046);
    br(1, 3);
    chk("br_rel_wrap", 32'(InstAddress), 32'd1);

    // Stall over a halt word, with a branch that must be lost
    step(0, 0, 0, 511, 1, 1, 0, 77);
    step(0, 0, 0, 511, 1, 0, 0, 0);
    step(0, 0, 0, 511, 1, 0, 0, 0);
    chk("stall_pc", 32'(InstAddress), 32'd1);
    chk("stall_running", 32'(Running), 32'd1);
    plain(511);
    chk("stall_halt", 32'(Done), 32'd1);
    plain(0);

    // Start ignored in RUN; reset aborts without Done
    step(0, 1, 0, 0, 0, 0, 0, 0);
    br(0, 40);
    step(0, 1, 2, 0, 0, 0, 0, 0);
    chk("start_in_run", 32'(InstAddress), 32'd41);
    step(1, 0, 0, 511, 0, 0, 0, 0);
    chk("abort_addr", 32'(InstAddress), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    plain(0);
    chk("abort_no_done", 32'(Done), 32'd0);

    // Counter saturation in a tight loop
    step(0, 1, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) br(0, 1024);
    chk("sat", 32'(CycleCount), 32'd65535);
    plain(511);
    plain(0);
    step(0, 1, 3, 0, 0, 0, 0, 0);
    chk("sel3_addr", 32'(InstAddress), 32'd0);
    chk("sel3_cycles", 32'(CycleCount), 32'd0);

    // Start held through the Done cycle
    plain(5);
    step(0, 1, 1, 511, 0, 0, 0, 0);
    chk("relaunch_done", 32'(Done), 32'd1);
    step(0, 1, 1, 511, 0, 0, 0, 0);
    chk("relaunch_run", 32'(Running), 32'd1);
    chk("relaunch_pc", 32'(InstAddress), 32'd512);
    chk("relaunch_done_low", 32'(Done), 32'd0);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199) == 0),
           ($urandom_range(3) == 0),
           int'($urandom_range(3)),
           ($urandom_range(7) == 0) ? 511 : int'($urandom_range(510)),
           ($urandom_range(4) == 0),
           ($urandom_range(2) == 0),
           $urandom_range(1) == 1,
           int'($urandom_range(2047)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
